// File: rtl/pci_debug_log_responder.sv
// pci_debug_log_responder
//   Captures trace entries into a ring buffer and answers PCI debug reads with
//   one header beat followed by arlen data beats (arlen+1 beats in total).
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   wvalid, wdata        trace entry capture (no backpressure; drops when full)
//   arvalid, arlen       debug read request pulse, beats requested minus one
//   rready               PCI side accepts the current beat
//   rdata, rvalid, rlast registered response beat
//   size                 current occupancy, zero-extended
// Optional feature macro: DEBUG_LOG_TIMESTAMP_EN stores a 32-bit cycle stamp
//   above each entry (data beat bits [WIDTH+31:WIDTH]).
module pci_debug_log_responder #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned LOG_DEPTH = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wvalid,
    input  logic [WIDTH-1:0] wdata,
    input  logic             arvalid,
    input  logic [7:0]       arlen,
    input  logic             rready,
    output logic [511:0]     rdata,
    output logic             rvalid,
    output logic             rlast,
    output logic [15:0]      size
);

    localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
    localparam int unsigned AW    = LOG_DEPTH;
    localparam int unsigned PW    = LOG_DEPTH + 1;
`ifdef DEBUG_LOG_TIMESTAMP_EN
    localparam int unsigned TSW   = 32;
`else
    localparam int unsigned TSW   = 0;
`endif
    localparam int unsigned EW    = WIDTH + TSW;

    // Parameter legality
    if (EW > 512 || LOG_DEPTH < 1 || LOG_DEPTH > 15) begin : g_param_chk
        $error("pci_debug_log_responder: WIDTH/LOG_DEPTH out of range");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_DATA = 2'd2} state_t;

    state_t          r_state, w_state_n;
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr, r_occ, w_rd_ptr_n, w_occ_n;
    logic [15:0]     r_drop, w_drop_n;
    logic [7:0]      r_beats_left, w_beats_n;
    logic            r_has_entry, w_has_n;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [EW-1:0]   r_head, r_nxt, w_head_n, w_nxt_n, w_entry;
    logic [AW-1:0]   w_wr_addr, w_rd_addr, w_rd_addr_n, w_look_addr;
    logic            w_full, w_hs, w_pop, w_push, w_drop, w_clr_drop;
    logic [511:0]    w_rdata_n, w_beat;
    logic            w_rvalid_n, w_rlast_n;

`ifdef DEBUG_LOG_TIMESTAMP_EN
    logic [31:0] r_ts;

    // Free-running capture timestamp
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_ts <= '0;
        else       r_ts <= r_ts + 32'd1;
    end

    assign w_entry = {r_ts, wdata};
`else
    assign w_entry = wdata;
`endif

    // Buffer status and handshakes; a beat shown as empty never pops
    assign w_full      = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                         (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
    assign w_hs        = rvalid && rready;
    assign w_pop       = (r_state == S_DATA) && w_hs && r_has_entry;
    assign w_push      = wvalid && (!w_full || w_pop);
    assign w_drop      = wvalid && !w_push;
    assign w_clr_drop  = (r_state == S_HDR) && w_hs;
    assign w_wr_addr   = r_wr_ptr[AW-1:0];
    assign w_rd_addr   = r_rd_ptr[AW-1:0];
    assign w_rd_ptr_n  = r_rd_ptr + PW'(w_pop);
    assign w_rd_addr_n = w_rd_ptr_n[AW-1:0];
    assign w_look_addr = w_rd_addr_n + AW'(1);
    assign size        = 16'(r_occ);

    // Prefetch: r_head = mem[rd_ptr], r_nxt = mem[rd_ptr+1], with same-cycle write bypass
    always_comb begin : p_prefetch
        w_nxt_n = r_mem[w_look_addr];
        if (w_push && (w_wr_addr == w_look_addr)) w_nxt_n = w_entry;
        if (w_pop) w_head_n = (w_push && (w_wr_addr == w_rd_addr_n)) ? w_entry : r_nxt;
        else       w_head_n = (w_push && (w_wr_addr == w_rd_addr)) ? w_entry : r_head;
        w_beat      = 512'(w_head_n);
        w_beat[511] = 1'b1;
    end

    // Occupancy and saturating drop counter
    always_comb begin : p_counts
        w_occ_n = r_occ;
        unique case ({w_push, w_pop})
            2'b10:   w_occ_n = r_occ + PW'(1);
            2'b01:   w_occ_n = r_occ - PW'(1);
            default: w_occ_n = r_occ;
        endcase
        w_drop_n = r_drop;
        if (w_clr_drop)                        w_drop_n = 16'(w_drop);
        else if (w_drop && r_drop != 16'hFFFF) w_drop_n = r_drop + 16'd1;
    end

    // Burst FSM: next state and next registered beat
    always_comb begin : p_next
        w_state_n  = r_state;
        w_beats_n  = r_beats_left;
        w_has_n    = r_has_entry;
        w_rdata_n  = rdata;
        w_rvalid_n = rvalid;
        w_rlast_n  = rlast;
        unique case (r_state)
            S_IDLE: if (arvalid) begin
                w_state_n  = S_HDR;
                w_beats_n  = arlen;
                w_has_n    = 1'b0;
                w_rvalid_n = 1'b1;
                w_rlast_n  = (arlen == 8'd0);
                w_rdata_n  = 512'({8'(LOG_DEPTH), w_drop_n, 16'(w_occ_n), 16'(arlen)});
            end
            S_HDR: if (w_hs) begin
                if (r_beats_left == 8'd0) begin
                    w_state_n  = S_IDLE;
                    w_rvalid_n = 1'b0;
                    w_rlast_n  = 1'b0;
                    w_rdata_n  = '0;
                end else begin
                    w_state_n = S_DATA;
                    w_has_n   = (w_occ_n != '0);
                    w_rdata_n = w_has_n ? w_beat : '0;
                    w_rlast_n = (r_beats_left == 8'd1);
                end
            end
            S_DATA: if (w_hs) begin
                w_beats_n = r_beats_left - 8'd1;
                if (r_beats_left == 8'd1) begin
                    w_state_n  = S_IDLE;
                    w_has_n    = 1'b0;
                    w_rvalid_n = 1'b0;
                    w_rlast_n  = 1'b0;
                    w_rdata_n  = '0;
                end else begin
                    w_has_n   = (w_occ_n != '0);
                    w_rdata_n = w_has_n ? w_beat : '0;
                    w_rlast_n = (r_beats_left == 8'd2);
                end
            end
            default: begin
                w_state_n  = S_IDLE;
                w_rvalid_n = 1'b0;
                w_rlast_n  = 1'b0;
                w_rdata_n  = '0;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_drop       <= '0;
            r_beats_left <= '0;
            r_has_entry  <= 1'b0;
            r_head       <= '0;
            rdata        <= '0;
            rvalid       <= 1'b0;
            rlast        <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_wr_ptr     <= r_wr_ptr + PW'(w_push);
            r_rd_ptr     <= w_rd_ptr_n;
            r_occ        <= w_occ_n;
            r_drop       <= w_drop_n;
            r_beats_left <= w_beats_n;
            r_has_entry  <= w_has_n;
            r_head       <= w_head_n;
            rdata        <= w_rdata_n;
            rvalid       <= w_rvalid_n;
            rlast        <= w_rlast_n;
        end
    end

    // Ring-buffer storage with registered lookahead read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_addr] <= w_entry;
        r_nxt <= w_nxt_n;
    end

endmodule
